control_unit: RTL

Hardwired instruction-sequencing FSM for the single-bus Datapath. It steps the Datapath through fetch (T0–T2) and the opcode-specific execute states, driving every strobe that the phase testbenches currently drive by hand. It sits beside the Datapath at CPU top level and decodes the IR value the Datapath exports. It also supports program halt and conditional-branch sequencing.

---
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control bundle between control_unit and the single-bus Datapath.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic [4:0]  CONTROL;
  logic        IncPC, Read, Write;
  logic        PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, CON_In;
  logic        G_RA, G_RB, G_RC;
  logic        Run;

  modport master (
    input  IR, CON,
    output CONTROL, IncPC, Read, Write,
    output PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out,
    output PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, CON_In,
    output G_RA, G_RB, G_RC, Run
  );

  modport slave (
    output IR, CON,
    input  CONTROL, IncPC, Read, Write,
    input  PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out,
    input  PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, CON_In,
    input  G_RA, G_RB, G_RC, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus Datapath.
// Define CTRL_BRANCH_EN to enable the conditional-branch (br) sequence.
module control_unit (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] C_ADD = 5'b00000;
  localparam logic [4:0] C_SUB = 5'b00001;
  localparam logic [4:0] C_AND = 5'b00010;
  localparam logic [4:0] C_OR  = 5'b00011;

  state_t     r_state, w_next;
  logic [4:0] w_op, w_ctl;
  logic       w_ld, w_ldi, w_st, w_mem, w_alu, w_imm, w_rr;
  logic       w_br, w_halt, w_con;
  logic       w_unused_ir;

  assign w_op   = bus.IR[31:27];
  assign w_ld   = (w_op == 5'b00000);
  assign w_ldi  = (w_op == 5'b00001);
  assign w_st   = (w_op == 5'b00010);
  assign w_mem  = w_ld | w_ldi | w_st;
  assign w_alu  = (w_op >= 5'b00011) && (w_op <= 5'b00110);
  assign w_imm  = (w_op >= 5'b01100) && (w_op <= 5'b01110);
  assign w_rr   = w_alu | w_imm;
  assign w_halt = (w_op == 5'b11011);

  assign w_unused_ir = ^bus.IR[26:0];

`ifdef CTRL_BRANCH_EN
  assign w_br  = (w_op == 5'b10011);
  assign w_con = bus.CON;
`else
  logic w_unused_con;
  assign w_br         = 1'b0;
  assign w_con        = 1'b0;
  assign w_unused_con = bus.CON;
`endif

  always_comb begin
    unique case (w_op)
      5'b00100:           w_ctl = C_SUB;
      5'b00101, 5'b01101: w_ctl = C_AND;
      5'b00110, 5'b01110: w_ctl = C_OR;
      default:            w_ctl = C_ADD;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.CONTROL = C_ADD;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.PC_Out  = 1'b0;
    bus.MDR_Out = 1'b0;
    bus.ZLO_Out = 1'b0;
    bus.C_Out   = 1'b0;
    bus.BA_Out  = 1'b0;
    bus.R_Out   = 1'b0;
    bus.PC_In   = 1'b0;
    bus.MDR_In  = 1'b0;
    bus.MAR_In  = 1'b0;
    bus.IR_In   = 1'b0;
    bus.Y_In    = 1'b0;
    bus.ZLO_In  = 1'b0;
    bus.R_In    = 1'b0;
    bus.CON_In  = 1'b0;
    bus.G_RA    = 1'b0;
    bus.G_RB    = 1'b0;
    bus.G_RC    = 1'b0;
    bus.Run     = (r_state != S_RESET) && (r_state != S_HALT);
    unique case (r_state)
      S_RESET: w_next = S_T0;
      S_T0: begin
        bus.PC_Out = 1'b1;
        bus.MAR_In = 1'b1;
        bus.IncPC  = 1'b1;
        w_next     = S_T1;
      end
      S_T1: begin
        bus.Read   = 1'b1;
        bus.MDR_In = 1'b1;
        w_next     = S_T2;
      end
      S_T2: begin
        bus.MDR_Out = 1'b1;
        bus.IR_In   = 1'b1;
        w_next      = S_T3;
      end
      S_T3: begin
        w_next = S_T4;
        unique case (1'b1)
          w_mem: begin
            bus.G_RB   = 1'b1;
            bus.BA_Out = 1'b1;
            bus.Y_In   = 1'b1;
          end
          w_rr: begin
            bus.G_RB  = 1'b1;
            bus.R_Out = 1'b1;
            bus.Y_In  = 1'b1;
          end
          w_br: begin
            bus.G_RA   = 1'b1;
            bus.R_Out  = 1'b1;
            bus.CON_In = 1'b1;
          end
          w_halt:  w_next = S_HALT;
          default: w_next = S_T0;
        endcase
      end
      S_T4: begin
        w_next = S_T5;
        unique case (1'b1)
          w_alu: begin
            bus.G_RC    = 1'b1;
            bus.R_Out   = 1'b1;
            bus.ZLO_In  = 1'b1;
            bus.CONTROL = w_ctl;
          end
          w_mem, w_imm: begin
            bus.C_Out   = 1'b1;
            bus.ZLO_In  = 1'b1;
            bus.CONTROL = w_ctl;
          end
          w_br: begin
            bus.PC_Out = 1'b1;
            bus.Y_In   = 1'b1;
          end
          default: w_next = S_T0;
        endcase
      end
      S_T5: begin
        w_next = S_T0;
        unique case (1'b1)
          w_ld, w_st: begin
            bus.ZLO_Out = 1'b1;
            bus.MAR_In  = 1'b1;
            w_next      = S_T6;
          end
          w_ldi, w_rr: begin
            bus.ZLO_Out = 1'b1;
            bus.G_RA    = 1'b1;
            bus.R_In    = 1'b1;
          end
          w_br: begin
            bus.C_Out  = 1'b1;
            bus.ZLO_In = 1'b1;
            w_next     = S_T6;
          end
          default: w_next = S_T0;
        endcase
      end
      S_T6: begin
        w_next = S_T0;
        unique case (1'b1)
          w_ld: begin
            bus.Read   = 1'b1;
            bus.MDR_In = 1'b1;
            w_next     = S_T7;
          end
          w_st: begin
            bus.G_RA   = 1'b1;
            bus.R_Out  = 1'b1;
            bus.MDR_In = 1'b1;
            w_next     = S_T7;
          end
          w_br: begin
            bus.ZLO_Out = w_con;
            bus.PC_In   = w_con;
          end
          default: w_next = S_T0;
        endcase
      end
      S_T7: begin
        w_next = S_T0;
        if (w_ld) begin
          bus.MDR_Out = 1'b1;
          bus.G_RA    = 1'b1;
          bus.R_In    = 1'b1;
        end else if (w_st) begin
          bus.Write = 1'b1;
        end
      end
      S_HALT: begin
        bus.Run = 1'b0;
        w_next  = S_HALT;
      end
      default: w_next = S_RESET;
    endcase
  end

endmodule
